// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Reset and lock sequencer for an ECP5 EHXPLLL. Holds the PLL in reset for a
// minimum time, waits (with timeout) for LOCK, debounces LOCK, and declares
// the generated clock good. Failed attempts are retried; too many consecutive
// failures latch a sticky fault. Runs entirely in the board input clock domain.
//
// Ports
//   clk_25m     in   board input clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   restart     in   synchronous request for a fresh sequence, from any state
//   pll_lock    in   raw PLL LOCK (asynchronous, synchronised here)
//   pll_rst     out  PLL RST, active-high
//   pll_ok      out  PLL locked and debounced (glitch-free, registered)
//   fault       out  retry budget exhausted; sticky until rst_n or restart
//   lock_loss   out  one-cycle pulse when lock drops while LOCKED
//   retries     out  consecutive failed attempts in the current sequence
//   loss_count  out  saturating count of lock_loss events since rst_n
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 2500,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 4
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       pll_ok,
    output logic       fault,
    output logic       lock_loss,
    output logic [3:0] retries,
    output logic [7:0] loss_count
);

    // Terminal counts: the counter starts at 0 in each state, so the last
    // cycle of a phase is the count minus one.
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;

    logic        pll_rst_next;
    logic        pll_ok_next;
    logic        fault_next;
    logic        lock_loss_next;
    logic [3:0]  retries_next;
    logic [7:0]  loss_count_next;
    logic        fail;

    // Two-flop synchroniser for the raw LOCK pin.
    logic lock_m, lock_s;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // State, counter and every output are registered together so that the
    // outputs change on exactly the edge that moves the state.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            pll_ok     <= 1'b0;
            fault      <= 1'b0;
            lock_loss  <= 1'b0;
            retries    <= '0;
            loss_count <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pll_rst    <= pll_rst_next;
            pll_ok     <= pll_ok_next;
            fault      <= fault_next;
            lock_loss  <= lock_loss_next;
            retries    <= retries_next;
            loss_count <= loss_count_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        pll_rst_next    = pll_rst;
        pll_ok_next     = pll_ok;
        fault_next      = fault;
        lock_loss_next  = 1'b0;
        retries_next    = retries;
        loss_count_next = loss_count;
        fail            = 1'b0;

        case (state)
            S_RESET: begin
                pll_rst_next = 1'b1;
                pll_ok_next  = 1'b0;
                if (cnt == RST_LAST) begin
                    state_next   = S_WAIT_LOCK;
                    cnt_next     = '0;
                    pll_rst_next = 1'b0;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            S_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_s) begin
                    state_next = S_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            S_STABLE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_next   = S_LOCKED;
                    cnt_next     = '0;
                    pll_ok_next  = 1'b1;
                    retries_next = '0;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            S_LOCKED: begin
                // Losing lock after a good lock is not a failed attempt:
                // retries is already 0 here and stays 0.
                if (!lock_s) begin
                    state_next     = S_RESET;
                    cnt_next       = '0;
                    pll_ok_next    = 1'b0;
                    pll_rst_next   = 1'b1;
                    lock_loss_next = 1'b1;
                    if (loss_count != 8'hFF) begin
                        loss_count_next = loss_count + 8'd1;
                    end
                end
            end

            S_FAULT: begin
                pll_rst_next = 1'b1;
                pll_ok_next  = 1'b0;
                fault_next   = 1'b1;
            end

            default: begin
                state_next   = S_RESET;
                cnt_next     = '0;
                pll_rst_next = 1'b1;
                pll_ok_next  = 1'b0;
            end
        endcase

        // A failed attempt either retries from RESET or, once the budget is
        // spent, parks in FAULT with the PLL held in reset.
        if (fail) begin
            cnt_next     = '0;
            pll_rst_next = 1'b1;
            pll_ok_next  = 1'b0;
            if (retries + 4'd1 == RETRY_LIMIT) begin
                state_next   = S_FAULT;
                retries_next = RETRY_LIMIT;
                fault_next   = 1'b1;
            end else begin
                state_next   = S_RESET;
                retries_next = retries + 4'd1;
            end
        end

        // restart overrides everything above, including a coincident fail or
        // lock loss; the loss history is deliberately kept.
        if (restart) begin
            state_next      = S_RESET;
            cnt_next        = '0;
            pll_rst_next    = 1'b1;
            pll_ok_next     = 1'b0;
            fault_next      = 1'b0;
            lock_loss_next  = 1'b0;
            retries_next    = '0;
            loss_count_next = loss_count;
        end
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

PLL reset and lock sequencer for the ECP5 `EHXPLLL` clock generators in the clock library. It runs on the board input clock and drives the PLL `RST` pin: a minimum power-up reset, then a wait for lock with a timeout. Lock is debounced before the block declares the clock good. It retries on timeout or lock loss and latches a fault after too many consecutive failures. Downstream logic consumes `pll_ok`, which is guaranteed glitch-free in the input-clock domain, and resynchronises it into the generated clock domain.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (1..65535).
- `LOCK_TIMEOUT`, 2500: cycles allowed in WAIT_LOCK before an attempt fails (100 µs at 25 MHz; 1..65535).
- `LOCK_STABLE`, 256: consecutive synchronised-lock-high cycles required before `pll_ok` (1..65535).
- `MAX_RETRY`, 4: consecutive failed attempts that trigger FAULT (1..15).
- `clk_25m`  in  1  input clock (25 MHz); the only clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `restart`  in  1  synchronous pulse that forces a fresh sequence from any state.
- `pll_lock`  in  1  raw PLL `LOCK`, asynchronous; double-flop synchronised internally to `lock_s`.
- `pll_rst`  out  1  drives PLL `RST`, active-high.
- `pll_ok`  out  1  PLL locked and debounced.
- `fault`  out  1  retry budget exhausted; sticky.
- `lock_loss`  out  1  one-cycle pulse when lock drops in LOCKED.
- `retries`  out  4  consecutive failed attempts in the current sequence.
- `loss_count`  out  8  saturating count of `lock_loss` events since `rst_n`.

## Operation
- Every output is a flop updated on the same edge as the state transition. Outputs are never decoded combinationally.
- Reset values (while `rst_n`=0):
  - state RESET, cnt=0
  - `pll_rst`=1
  - `pll_ok`=0, `fault`=0, `lock_loss`=0
  - `retries`=0, `loss_count`=0
  - sync flops=0
- One 16-bit counter `cnt`. It is cleared on every state change.
- States:
  - RESET: `pll_rst`=1 and `pll_ok`=0. When cnt==RST_CYCLES-1, go to WAIT_LOCK with `pll_rst`=0. Otherwise cnt increments.
  - WAIT_LOCK: if `lock_s`=1, go to STABLE. Otherwise, when cnt==LOCK_TIMEOUT-1, the attempt **fails**. Otherwise cnt increments. If timeout and `lock_s`=1 occur on the same edge, lock wins.
  - STABLE: if `lock_s`=0, the attempt **fails**. If `lock_s`=1 and cnt==LOCK_STABLE-1, go to LOCKED: `pll_ok`=1 and `retries`=0. Otherwise cnt increments.
  - LOCKED: if `lock_s`=0, go to RESET:
    - `pll_ok`=0
    - `pll_rst`=1
    - `lock_loss`=1 for that cycle
    - `loss_count`+1, saturating at 255
    - `retries` unchanged (it is already 0)
  - FAULT: `pll_rst`=1, `fault`=1, `pll_ok`=0. It is left only by `rst_n` or `restart`.
- A **fail** does the following:
  - If `retries`+1==MAX_RETRY, go to FAULT with `retries`=MAX_RETRY.
  - Otherwise go to RESET with `retries`+1.
  - In both cases `pll_rst` goes to 1.
- `restart`=1 on an edge overrides all other conditions in any state:
  - go to RESET with cnt=0
  - `retries`=0, `fault`=0, `pll_ok`=0, `pll_rst`=1
  - `loss_count` is kept
  - `lock_loss` is not pulsed
- `restart` held high keeps the block in RESET.
- `rst_n` asserted mid-operation returns all flops to their reset values immediately, asynchronously.

## Timing
- `rst_n` release: the first edge after release is RESET cycle 0. `pll_rst` falls on edge RST_CYCLES (counting from 1).
- Lock synchroniser: a `pll_lock` rise sampled at edge A appears as `lock_s`=1 at edge A+1 and is acted on at edge A+2.
- Lock to `pll_ok`: with lock first acted on at edge E0 (move to STABLE), `pll_ok` rises at edge E0+LOCK_STABLE. From the raw edge this is A+2+LOCK_STABLE.
- Timeout: with the lock never seen, the fail happens on the LOCK_TIMEOUT-th edge in WAIT_LOCK.
- Lock loss: a raw drop at edge A makes `pll_ok` fall at edge A+2. `pll_rst` rises on the same edge.
- A full retry cycle costs RST_CYCLES+LOCK_TIMEOUT clocks. There are no idle gaps between states.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=3.
- **Nominal lock:** release `rst_n`, raise `pll_lock` 5 cycles after `pll_rst` falls and hold it -> `pll_rst` high exactly 4 cycles; `pll_ok` rises 10 edges after the first edge sampling `pll_lock`=1; `retries`=0, `fault`=0.
- **Timeout and fault:** keep `pll_lock`=0 -> three `pll_rst` pulses of 4 cycles, each followed by 20 low cycles; `retries` steps 1, 2, then 3 with `fault`=1 and `pll_rst` held high permanently; then pulse `restart` -> `fault`=0, `retries`=0, and a new 4-cycle reset.
- **Debounce:** lock high for 5 cycles, low, then high steadily -> no `pll_ok` during the glitch, `retries`=1 after it, and the second attempt reaches LOCKED with `retries` back to 0.
- **Lock loss:** in LOCKED, drop `pll_lock` for 1 cycle -> `pll_ok` falls 2 edges later, with a 1-cycle `lock_loss` pulse, `loss_count`=1, and `pll_rst` high for 4 cycles; it relocks normally. Repeat 300 times -> `loss_count` saturates at 255.
- **Simultaneous events:** lock sampled on the same edge as the timeout -> STABLE is entered and `retries` is unchanged. `restart` on the edge a fail would occur -> `retries`=0, not incremented.
- **Async reset mid-sequence:** pulse `rst_n` low for a fraction of a cycle while in STABLE -> all outputs take their reset values immediately, with no clock edge required; the sequence then restarts from RESET cycle 0.
